// File: rtl/led_drv_pkg.sv
// Shared types and constants for the LED pattern driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_drv_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_CHASE  = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_OFF    = 2'b11
  } mode_e;

  localparam logic [2:0] DEFAULT_ENABLE_CODE = 3'd4;
  localparam int         LED_MAX_W           = 64;

  // Low w bits set; callers truncate to their own LED width.
  function automatic logic [LED_MAX_W-1:0] led_off(input int w);
    led_off = '0;
    for (int i = 0; i < LED_MAX_W; i++) begin
      if (i < w) led_off[i] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler producing a one-cycle pattern step every TICK_DIV running cycles.
// Latency: tick is combinational from the registered count.
// Backpressure: holds the count while run is low; clear wins over counting.
module led_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = run & ~clear & (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_driver.sv
// Active-low LED bank driver: static select, chase, blink or off; LED_CHASE_BOUNCE_EN makes chase ping-pong.
// Latency: one clock from any input to led.
// Backpressure: none; a wrong enable code blanks the LEDs and freezes pattern state.
module led_pattern_driver
  import led_drv_pkg::*;
#(
  parameter int         SEL_W       = 3,
  parameter int         OUT_W       = 8,
  parameter logic [2:0] ENABLE_CODE = DEFAULT_ENABLE_CODE,
  parameter int         TICK_DIV    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       enable,
  input  logic [SEL_W-1:0] switch,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] led
);

  localparam logic [OUT_W-1:0] LED_ALL = OUT_W'(led_off(OUT_W));
  localparam logic [SEL_W-1:0] LAST    = SEL_W'(OUT_W - 1);

  function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] x);
    if (x > LAST) return LED_ALL;
    return ~(OUT_W'(1) << x);
  endfunction

  mode_e            mode_q;
  logic [SEL_W-1:0] pos;
  logic [SEL_W-1:0] pos_next;
  logic [SEL_W-1:0] sw_clamp;
  logic             phase;
  logic             phase_next;
  logic             en_ok;
  logic             mode_chg;
  logic             tick;

  assign en_ok      = (enable == ENABLE_CODE);
  assign mode_chg   = en_ok && (mode != mode_q);
  assign sw_clamp   = (switch > LAST) ? LAST : switch;
  assign phase_next = tick ? ~phase : phase;

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .run   (en_ok),
    .clear (mode_chg),
    .tick  (tick)
  );

`ifdef LED_CHASE_BOUNCE_EN
  logic dir;      // 0 = counting up
  logic dir_next;

  always_comb begin
    pos_next = pos;
    dir_next = dir;
    if (!dir) begin
      if (pos == LAST) begin
        pos_next = LAST - 1'b1;
        dir_next = 1'b1;
      end else begin
        pos_next = pos + 1'b1;
      end
    end else begin
      if (pos == '0) begin
        pos_next = SEL_W'(1);
        dir_next = 1'b0;
      end else begin
        pos_next = pos - 1'b1;
      end
    end
  end
`else
  assign pos_next = (pos == LAST) ? '0 : pos + 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      led    <= LED_ALL;
      pos    <= '0;
      phase  <= 1'b0;
      mode_q <= MODE_STATIC;
`ifdef LED_CHASE_BOUNCE_EN
      dir    <= 1'b0;
`endif
    end else if (!en_ok) begin
      led <= LED_ALL;
    end else if (mode_chg) begin
      // Entry cycle: the prescaler restarts, so no step happens here.
      mode_q <= mode_e'(mode);
      phase  <= 1'b0;
      pos    <= sw_clamp;
`ifdef LED_CHASE_BOUNCE_EN
      dir    <= 1'b0;
`endif
      led    <= (mode == MODE_OFF) ? LED_ALL : decode(switch);
    end else begin
      case (mode_q)
        MODE_STATIC: led <= decode(switch);
        MODE_CHASE: begin
          if (tick) begin
            pos <= pos_next;
`ifdef LED_CHASE_BOUNCE_EN
            dir <= dir_next;
`endif
            led <= decode(pos_next);
          end else begin
            led <= decode(pos);
          end
        end
        MODE_BLINK: begin
          phase <= phase_next;
          led   <= phase_next ? LED_ALL : decode(switch);
        end
        default: led <= LED_ALL;
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_driver.sv
// Bench for led_pattern_driver: an 8-LED and a 6-LED instance share stimulus and a step-count reference model.
module tb_led_pattern_driver;

  localparam int TD = 4;

  logic       clk    = 1'b0;
  logic       rst    = 1'b0;
  logic [2:0] enable = 3'd4;
  logic [2:0] sw     = 3'd0;
  logic [1:0] mode   = 2'b00;
  logic [7:0] led8;
  logic [5:0] led6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_pattern_driver dut (
    .clk(clk), .rst(rst), .enable(enable), .switch(sw), .mode(mode), .led(led8)
  );

  led_pattern_driver #(.SEL_W(3), .OUT_W(6), .ENABLE_CODE(3'd4), .TICK_DIV(TD)) dut6 (
    .clk(clk), .rst(rst), .enable(enable), .switch(sw), .mode(mode), .led(led6)
  );

  // Reference model: per instance, the active mode, the enabled cycles since entry and the entry position.
  int         mw      [2] = '{8, 6};
  int         m_mode  [2];
  int         m_k     [2];
  int         m_start [2];
  logic [7:0] m_led   [2];

  function automatic logic [7:0] ones(input int w);
    return 8'((1 << w) - 1);
  endfunction

  function automatic logic [7:0] dec(input int w, input int x);
    if (x >= w) return ones(w);
    return ones(w) & ~8'(1 << x);
  endfunction

  function automatic int chase_pos(input int w, input int s, input int n);
`ifdef LED_CHASE_BOUNCE_EN
    int p;
    int t;
    p = 2 * (w - 1);
    t = (s + n) % p;
    return (t <= w - 1) ? t : p - t;
`else
    return (s + n) % w;
`endif
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int w;
      int steps;
      w = mw[i];
      if (!rst) begin
        m_led[i] = ones(w); m_mode[i] = 0; m_k[i] = 0; m_start[i] = 0;
      end else if (enable != 3'd4) begin
        m_led[i] = ones(w);
      end else if (int'(mode) != m_mode[i]) begin
        m_mode[i]  = int'(mode);
        m_k[i]     = 0;
        m_start[i] = (int'(sw) >= w) ? w - 1 : int'(sw);
        m_led[i]   = (mode == 2'b11) ? ones(w) : dec(w, int'(sw));
      end else begin
        m_k[i]++;
        steps = m_k[i] / TD;
        case (m_mode[i])
          0:       m_led[i] = dec(w, int'(sw));
          1:       m_led[i] = dec(w, chase_pos(w, m_start[i], steps));
          2:       m_led[i] = (steps % 2 == 1) ? ones(w) : dec(w, int'(sw));
          default: m_led[i] = ones(w);
        endcase
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; mode = 2'b01; enable = 3'd4; sw = 3'd3;
    cyc();
    checks++; if (led8 !== 8'hFF) begin errors++; $display("FAIL reset_led got %h expected ff", led8); end
    checks++; if (led6 !== 6'h3F) begin errors++; $display("FAIL reset_led6 got %h expected 3f", led6); end
    checks++; if (dut.pos !== 3'd0) begin errors++; $display("FAIL reset_pos got %0d expected 0", dut.pos); end
    checks++; if (dut.mode_q !== 2'b00) begin errors++; $display("FAIL reset_mode got %0d expected 0", dut.mode_q); end
    mode = 2'b00;
    rst  = 1'b1;
  endtask

  task automatic test_static();
    sw = 3'd3; cyc();
    checks++; if (led8 !== 8'hF7) begin errors++; $display("FAIL static_sw3 got %h expected f7", led8); end
    enable = 3'd5; cyc();
    checks++; if (led8 !== 8'hFF) begin errors++; $display("FAIL static_disabled got %h expected ff", led8); end
    enable = 3'd4; sw = 3'd0; cyc();
    checks++; if (led8 !== 8'hFE) begin errors++; $display("FAIL static_sw0 got %h expected fe", led8); end
  endtask

  task automatic test_chase();
    logic [7:0] exp;
    mode = 2'b01; sw = 3'd6;
    for (int i = 0; i < 9; i++) begin
      cyc();
      sw = 3'($urandom_range(0, 7));
`ifdef LED_CHASE_BOUNCE_EN
      exp = (i < 4) ? 8'hBF : (i < 8) ? 8'h7F : 8'hBF;
`else
      exp = (i < 4) ? 8'hBF : (i < 8) ? 8'h7F : 8'hFE;
`endif
      checks++; if (led8 !== exp) begin errors++; $display("FAIL chase_%0d got %h expected %h", i, led8, exp); end
    end
  endtask

  task automatic test_blink();
    logic [7:0] exp;
    mode = 2'b10; sw = 3'd0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      exp = ((i / 4) % 2 == 1) ? 8'hFF : 8'hFE;
      checks++; if (led8 !== exp) begin errors++; $display("FAIL blink_%0d got %h expected %h", i, led8, exp); end
    end
    enable = 3'd0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (led8 !== 8'hFF) begin errors++; $display("FAIL blink_off_%0d got %h expected ff", i, led8); end
    end
    enable = 3'd4;
    for (int i = 0; i < 3; i++) begin
      cyc();
      exp = (i < 2) ? 8'hFE : 8'hFF;
      checks++; if (led8 !== exp) begin errors++; $display("FAIL blink_resume_%0d got %h expected %h", i, led8, exp); end
    end
  endtask

  task automatic test_reset_mid();
    mode = 2'b01; sw = 3'd2;
    for (int i = 0; i < 16; i++) cyc();
    checks++; if (led8 !== 8'hDF) begin errors++; $display("FAIL mid_pos5 got %h expected df", led8); end
    rst = 1'b0; sw = 3'd1;
    cyc();
    checks++; if (led8 !== 8'hFF) begin errors++; $display("FAIL mid_reset_led got %h expected ff", led8); end
    checks++; if (dut.pos !== 3'd0) begin errors++; $display("FAIL mid_reset_pos got %0d expected 0", dut.pos); end
    rst = 1'b1;
    cyc();
    checks++; if (led8 !== 8'hFD) begin errors++; $display("FAIL mid_reentry_led got %h expected fd", led8); end
    checks++; if (dut.pos !== 3'd1) begin errors++; $display("FAIL mid_reentry_pos got %0d expected 1", dut.pos); end
  endtask

  task automatic test_narrow();
    logic [5:0] exp;
    mode = 2'b00; sw = 3'd7;
    cyc(); cyc();
    checks++; if (led6 !== 6'h3F) begin errors++; $display("FAIL narrow_sw7 got %h expected 3f", led6); end
    checks++; if (led8 !== 8'h7F) begin errors++; $display("FAIL wide_sw7 got %h expected 7f", led8); end
    sw = 3'd5; cyc();
    checks++; if (led6 !== 6'h1F) begin errors++; $display("FAIL narrow_sw5 got %h expected 1f", led6); end
    mode = 2'b01;
    for (int i = 0; i < 5; i++) begin
      cyc();
`ifdef LED_CHASE_BOUNCE_EN
      exp = (i < 4) ? 6'h1F : 6'h2F;
`else
      exp = (i < 4) ? 6'h1F : 6'h3E;
`endif
      checks++; if (led6 !== exp) begin errors++; $display("FAIL narrow_chase_%0d got %h expected %h", i, led6, exp); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst    = ($urandom_range(0, 79) != 0);
      enable = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd4;
      if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
      sw = 3'($urandom_range(0, 7));
      cyc();
      checks++; if (led8 !== m_led[0]) begin errors++; $display("FAIL rand8_%0d got %h expected %h", n, led8, m_led[0]); end
      checks++; if (led6 !== m_led[1][5:0]) begin errors++; $display("FAIL rand6_%0d got %h expected %h", n, led6, m_led[1][5:0]); end
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_static();
    test_chase();
    test_blink();
    test_reset_mid();
    test_narrow();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pattern_driver.md
Name: led_pattern_driver

Overview:
- Parametrised successor to the registered one-of-N active-low LED decoder.
- Adds three things: generic select/output width, a programmable enable code, and mode-driven sequential patterns (static, chase, blink, off) paced by an internal prescaler.
- Sits between the board switch/enable inputs and the LED bank; outputs are active-low (0 = lit).

Parameters:
- SEL_W, 3: width of switch select.
- OUT_W, 8: number of LEDs; 1 < OUT_W <= 2**SEL_W.
- ENABLE_CODE, 3'd4: enable value that activates the block.
- TICK_DIV, 4: clock cycles per pattern step; must be >= 1.

Ports:
- clk  in  1: clock, rising-edge.
- rst  in  1: synchronous, active-low reset.
- enable  in  3: block active only when enable == ENABLE_CODE (en_ok).
- switch  in  SEL_W: LED select / chase start position.
- mode  in  2: 00 STATIC, 01 CHASE, 10 BLINK, 11 OFF.
- led  out  OUT_W: registered LED drive, active-low.

Behaviour:
- Interface: one clock; reset is synchronous and active-low; ports are named clk and rst.
- Reset (rst==0 at posedge):
  - led=all ones; cnt=0; pos=0; phase=0; dir=up; mode_q=STATIC.
  - Reset overrides every other event in the same cycle.
- Latency: all state and led are registered; an input change is visible on led after 1 edge.
- decode(x) = ~(1<<x) truncated to OUT_W; any x >= OUT_W gives all ones.
- Disabled (!en_ok): led<=all ones; cnt, pos, phase, dir and mode_q hold.
- Mode change (en_ok && mode != mode_q):
  - mode_q<=mode; cnt<=0; phase<=0; pos<=switch (clamped to OUT_W-1 if larger); dir<=up.
  - led<=decode(switch), or all ones if mode==OFF.
  - No step occurs in that cycle, even if cnt==TICK_DIV-1.
- Prescaler (en_ok, no mode change):
  - cnt increments 0..TICK_DIV-1, then wraps to 0.
  - tick = (cnt==TICK_DIV-1).
  - TICK_DIV==1 gives a tick every enabled cycle.
- STATIC: led<=decode(switch), tracking switch every cycle; tick has no effect.
- CHASE:
  - On tick: pos<=pos_next, led<=decode(pos_next).
  - Otherwise led<=decode(pos).
  - pos_next: OUT_W-1 wraps to 0.
  - switch is ignored after entry.
- BLINK:
  - On tick: phase<=~phase.
  - led<=phase_next ? all ones : decode(switch).
  - switch changes take effect at the next edge.
- OFF: led<=all ones; cnt runs but pos and phase hold.

Optional Feature:
- Macro: LED_CHASE_BOUNCE_EN.
- Defined: CHASE ping-pongs.
  - dir=up increments pos; at OUT_W-1 dir flips and pos_next=OUT_W-2.
  - dir=down decrements pos; at 0 dir flips and pos_next=1.
  - Entry at an endpoint starts with dir=up, so entry at OUT_W-1 steps down on the first tick.
- Undefined: wrap-around chase only; dir register is absent.

Decomposition:
- Package led_drv_pkg:
  - mode enum typedef (MODE_STATIC, MODE_CHASE, MODE_BLINK, MODE_OFF).
  - default ENABLE_CODE constant.
  - LED_OFF all-ones helper function parametrised by width.
- Sub-module led_tick_gen (TICK_DIV):
  - inputs clk, rst, run, clear; output tick.
  - holds when run==0; clear has priority over counting.

Test Plan (SEL_W=3, OUT_W=8, TICK_DIV=4 unless noted):
- Reset: rst=0 for 1 edge while mode=CHASE, enable=4 -> led=8'hFF next cycle; mode_q=STATIC, pos=0.
- STATIC gating: enable=4, switch=3 -> led=8'hF7 after 1 edge. Then enable=5 -> 8'hFF. Then enable=4, switch=0 -> 8'hFE.
- CHASE wrap: enable=4, mode 00->01 with switch=6:
  - led=8'hBF for 4 cycles, then 8'h7F for 4, then 8'hFE.
  - With LED_CHASE_BOUNCE_EN: 8'hBF -> 8'h7F -> 8'hBF.
- BLINK with mid-run disable: mode=10, switch=0:
  - led=8'hFE for 4 cycles, then 8'hFF for 4, repeating.
  - Drop enable to 0 for 3 cycles mid-phase -> 8'hFF.
  - Restore enable -> resumes with remaining phase count; no extra toggle.
- Reset mid-pattern: CHASE at pos=5 with rst=0 on the same edge as a tick -> led=8'hFF, pos=0, no step. After release with mode=01 -> mode change detected, pos<=switch.
- Narrow output (OUT_W=6): STATIC, switch=7 -> led=6'h3F. Switch=5 -> 6'h1F. CHASE from 5 wraps to led=6'h3E.
